// File: rtl/mwb_mem_stage.sv
// rtl/mwb_mem_stage.sv - MWB stage: data-memory handshake, load alignment, register-file writeback
module mwb_mem_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_instruction,
   input  logic [31:0]       i_alu_result,
   input  logic [31:0]       i_imme_result,
   input  logic [31:0]       i_pc,
   input  logic [DATA_W-1:0] i_iomem_data,
   input  logic              i_reg_we,
   input  logic [1:0]        i_dmem_sel,
   input  logic [2:0]        i_load_sel,
   input  logic [1:0]        i_wb_sel,
   output logic              o_mem_req_valid,
   input  logic              i_mem_req_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [3:0]        o_mem_be,
   input  logic              i_mem_rsp_valid,
   input  logic [DATA_W-1:0] i_mem_rsp_rdata,
   output logic              o_stall,
   output logic              o_misalign,
   output logic              o_rf_we,
   output logic [4:0]        o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t              r_state;
   logic                r_req_valid;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [3:0]          r_mem_be;
   logic [DATA_W-1:0]   r_load_data;

   logic                w_is_load;
   logic                w_is_store;
   logic                w_mem_op;
   logic [1:0]          w_size;
   logic [1:0]          w_lane;
   logic                w_lane_bad;
   logic                w_misalign;
   logic                w_start;
   logic [3:0]          w_be;
   logic [DATA_W-1:0]   w_wdata;
   logic [7:0]          w_ld_byte;
   logic [15:0]         w_ld_half;
   logic [DATA_W-1:0]   w_ld_aligned;
   logic [DATA_W-1:0]   w_wb_data;
   logic                w_unused_bits;

   // instruction bits outside funct3/rd are decoded upstream
   assign w_unused_bits = &{1'b0, i_instruction[31:15], i_instruction[6:0]};

   assign w_is_load  = (i_dmem_sel == 2'b01);
   assign w_is_store = (i_dmem_sel == 2'b10);
   assign w_mem_op   = w_is_load | w_is_store;
   // loads size from load_sel, stores from the instruction's funct3
   assign w_size     = w_is_load ? i_load_sel[1:0] : i_instruction[13:12];
   assign w_lane     = i_alu_result[1:0];

   // access size decides which address bits must be zero
   always_comb begin
      w_lane_bad = 1'b0;
      case (w_size)
         2'b00:   w_lane_bad = 1'b0;
         2'b01:   w_lane_bad = w_lane[0];
         default: w_lane_bad = |w_lane;
      endcase
   end

   assign w_misalign = w_mem_op & w_lane_bad;
   assign w_start    = (r_state == S_IDLE) & w_mem_op & ~w_misalign;

   // byte enables and lane-replicated store data for the request
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_iomem_data;
      case (w_size)
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_iomem_data[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{i_iomem_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_iomem_data;
         end
      endcase
   end

   // request/response sequencing; request fields are held from capture to accept
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_req_valid <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= 4'b0000;
         r_load_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_mem_we    <= w_is_store;
                  r_mem_addr  <= {i_alu_result[ADDR_W-1:2], 2'b00};
                  r_mem_wdata <= w_wdata;
                  r_mem_be    <= w_be;
                  r_req_valid <= 1'b1;
                  r_state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (i_mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= r_mem_we ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_mem_rsp_valid) begin
                  r_load_data <= i_mem_rsp_rdata;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               // the finished instruction is still on the inputs; never re-issue it
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // pick the addressed byte/half of the captured load word
   always_comb begin
      w_ld_byte = r_load_data[7:0];
      case (w_lane)
         2'b00: w_ld_byte = r_load_data[7:0];
         2'b01: w_ld_byte = r_load_data[15:8];
         2'b10: w_ld_byte = r_load_data[23:16];
         2'b11: w_ld_byte = r_load_data[31:24];
         default: w_ld_byte = r_load_data[7:0];
      endcase
      w_ld_half = w_lane[1] ? r_load_data[31:16] : r_load_data[15:0];
   end

   // sign or zero extension by funct3
   always_comb begin
      w_ld_aligned = r_load_data;
      case (i_load_sel)
         3'b000:  w_ld_aligned = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_aligned = {{16{w_ld_half[15]}}, w_ld_half};
         3'b100:  w_ld_aligned = {24'd0, w_ld_byte};
         3'b101:  w_ld_aligned = {16'd0, w_ld_half};
         default: w_ld_aligned = r_load_data;
      endcase
   end

   // writeback source select
   always_comb begin
      w_wb_data = i_alu_result;
      case (i_wb_sel)
         2'b00:   w_wb_data = i_alu_result;
         2'b01:   w_wb_data = w_ld_aligned;
         2'b10:   w_wb_data = i_pc + 32'd4;
         default: w_wb_data = i_imme_result;
      endcase
   end

   assign o_mem_req_valid = r_req_valid;
   assign o_mem_we        = r_mem_we;
   assign o_mem_addr      = r_mem_addr;
   assign o_mem_wdata     = r_mem_wdata;
   assign o_mem_be        = r_mem_be;

   assign o_stall    = ~rst & (w_start | (r_state == S_REQ) | (r_state == S_WAIT));
   assign o_misalign = ~rst & (r_state == S_IDLE) & w_misalign;
   assign o_rf_waddr = i_instruction[11:7];
   assign o_rf_wdata = w_wb_data;
   // non-memory ops write in IDLE; loads write once, in DONE; stores never write
   assign o_rf_we    = ~rst & i_reg_we & (o_rf_waddr != 5'd0) &
                       (((r_state == S_IDLE) & ~w_mem_op) |
                        ((r_state == S_DONE) & ~r_mem_we));

endmodule

// File: tb/tb_mwb_mem_stage.sv
// tb/tb_mwb_mem_stage.sv - self-checking bench for mwb_mem_stage
module tb_mwb_mem_stage;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] alu_result;
   logic [31:0] imme_result;
   logic [31:0] pc;
   logic [31:0] iomem_data;
   logic        reg_we;
   logic [1:0]  dmem_sel;
   logic [2:0]  load_sel;
   logic [1:0]  wb_sel;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        stall;
   logic        misalign;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rdata;

   mwb_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_instruction(instruction), .i_alu_result(alu_result),
      .i_imme_result(imme_result), .i_pc(pc), .i_iomem_data(iomem_data),
      .i_reg_we(reg_we), .i_dmem_sel(dmem_sel), .i_load_sel(load_sel),
      .i_wb_sel(wb_sel), .o_mem_req_valid(mem_req_valid),
      .i_mem_req_ready(mem_req_ready), .o_mem_we(mem_we),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
      .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_rdata(mem_rsp_rdata),
      .o_stall(stall), .o_misalign(misalign), .o_rf_we(rf_we),
      .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int access_bytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
      int nb;
      longint unsigned v;
      longint unsigned span;
      nb = access_bytes(f3);
      if (nb == 4) return word;
      span = 64'd1 << (8 * nb);
      v = longint'(word) >> (8 * int'(lane));
      v = v % span;
      if (f3[2] == 1'b0 && v >= span / 2) v = 64'h1_0000_0000 - (span - v);
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lane);
      int nb;
      int v;
      nb = access_bytes(f3);
      v = ((1 << nb) - 1) << int'(lane);
      return v[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      int nb;
      logic [31:0] w;
      logic [31:0] b;
      nb = access_bytes(f3);
      w = 32'd0;
      for (int i = 0; i < 4; i++) begin
         b = (rs2 >> (8 * (i % nb))) & 32'hFF;
         w = w | (b << (8 * i));
      end
      return w;
   endfunction

   // one instruction through the stage; returns once the stage is back in IDLE
   task automatic run_op(input logic [1:0] dsel, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [31:0] pcv, input logic [31:0] imm,
                         input logic [4:0] rd, input logic rwe, input logic [1:0] wsel,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
      logic [31:0] ins;
      logic [31:0] exp_wb;
      logic        exp_we;
      logic        is_ld;
      logic        is_st;
      logic        bad;
      int          stalls;
      int          nb;
      ins = $urandom;
      ins[14:12] = f3;
      ins[11:7]  = rd;
      is_ld = (dsel == 2'b01);
      is_st = (dsel == 2'b10);
      ins[6:0] = is_ld ? 7'h03 : (is_st ? 7'h23 : 7'h33);
      instruction = ins; alu_result = alu; iomem_data = rs2; pc = pcv;
      imme_result = imm; reg_we = rwe; dmem_sel = dsel; load_sel = f3; wb_sel = wsel;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      nb = access_bytes(f3);
      bad = (is_ld || is_st) && ((int'(alu[1:0]) % nb) != 0);
      exp_we = rwe && (rd != 5'd0);
      case (wsel)
         2'b00: exp_wb = alu;
         2'b01: exp_wb = model_load(is_ld ? rdata : last_rdata, f3, alu[1:0]);
         2'b10: exp_wb = pcv + 32'd4;
         default: exp_wb = imm;
      endcase
      #1;
      if (!is_ld && !is_st) begin
         check("nm_stall", stall, 0);
         check("nm_misalign", misalign, 0);
         check("nm_rf_we", rf_we, exp_we);
         check("nm_waddr", rf_waddr, rd);
         if (exp_we) check("nm_wdata", rf_wdata, exp_wb);
         step;
         return;
      end
      if (bad) begin
         check("mis_flag", misalign, 1);
         check("mis_stall", stall, 0);
         check("mis_rf_we", rf_we, 0);
         step;
         check("mis_no_req", mem_req_valid, 0);
         return;
      end
      check("idle_stall", stall, 1);
      check("idle_misalign", misalign, 0);
      check("idle_rf_we", rf_we, 0);
      stalls = 1;
      step;
      for (int k = 0; k <= rdy_dly; k++) begin
         mem_req_ready = (k == rdy_dly);
         mem_rsp_valid = 1'b1;
         mem_rsp_rdata = $urandom;
         #1;
         check("req_valid", mem_req_valid, 1);
         check("req_addr", mem_addr, alu & 32'hFFFF_FFFC);
         check("req_we", mem_we, is_st);
         check("req_be", mem_be, model_be(f3, alu[1:0]));
         if (is_st) check("req_wdata", mem_wdata, model_wdata(f3, rs2));
         check("req_stall", stall, 1);
         check("req_rf_we", rf_we, 0);
         stalls++;
         step;
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (is_ld) begin
         for (int k = 0; k <= rsp_dly; k++) begin
            mem_rsp_valid = (k == rsp_dly);
            mem_rsp_rdata = (k == rsp_dly) ? rdata : $urandom;
            #1;
            check("wait_stall", stall, 1);
            check("wait_req", mem_req_valid, 0);
            check("wait_rf_we", rf_we, 0);
            stalls++;
            step;
         end
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = ~rdata;
      #1;
      check("done_stall", stall, 0);
      check("done_req", mem_req_valid, 0);
      check("done_rf_we", rf_we, is_ld && exp_we);
      if (is_ld && exp_we) check("done_wdata", rf_wdata, exp_wb);
      check("stall_cycles", stalls, 1 + (rdy_dly + 1) + (is_ld ? rsp_dly + 1 : 0));
      if (is_ld) last_rdata = rdata;
      step;
      mem_rsp_valid = 1'b0;
      check("post_no_reissue", mem_req_valid, 0);
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      logic [1:0] ds;
      logic [2:0] f3;
      logic [1:0] ws;
      logic [31:0] a;
      ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
      ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
      last_rdata = 32'd0;
      rst = 1'b1;
      instruction = 32'd0; alu_result = 32'd0; imme_result = 32'd0; pc = 32'd0;
      iomem_data = 32'd0; reg_we = 1'b0; dmem_sel = 2'b00; load_sel = 3'b000;
      wb_sel = 2'b00; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
      step;
      step;
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_we", mem_we, 0);
      check("rst_be", mem_be, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_stall", stall, 0);
      check("rst_misalign", misalign, 0);
      check("rst_rf_we", rf_we, 0);
      rst = 1'b0;
      step;

      // ADD x5
      run_op(2'b00, 3'b000, 32'h1234, 32'd0, 32'h100, 32'd0, 5'd5, 1'b1, 2'b00, 0, 0, 32'd0);
      // LB from 0x103, fastest memory
      run_op(2'b01, 3'b000, 32'h103, 32'd0, 32'h104, 32'd0, 5'd7, 1'b1, 2'b01, 0, 0, 32'h80FF_0000);
      check("lb_value", last_rdata, 32'h80FF_0000);
      // SH to 0x202 with ready held low two cycles
      run_op(2'b10, 3'b001, 32'h202, 32'hABCD, 32'h108, 32'd0, 5'd9, 1'b1, 2'b00, 2, 0, 32'd0);
      // misaligned LW
      run_op(2'b01, 3'b010, 32'h101, 32'd0, 32'h10C, 32'd0, 5'd4, 1'b1, 2'b01, 0, 0, 32'd0);
      // JAL wrap-around, then rd = x0
      run_op(2'b00, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 5'd1, 1'b1, 2'b10, 0, 0, 32'd0);
      run_op(2'b00, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 5'd0, 1'b1, 2'b10, 0, 0, 32'd0);
      // reserved dmem_sel behaves as a non-memory op
      run_op(2'b11, 3'b010, 32'h55, 32'd0, 32'h0, 32'h777, 5'd3, 1'b1, 2'b11, 0, 0, 32'd0);

      // reset while waiting for a load response
      instruction = 32'h0000_2283; alu_result = 32'h100; dmem_sel = 2'b01; load_sel = 3'b010;
      reg_we = 1'b1; wb_sel = 2'b01;
      step;
      mem_req_ready = 1'b1;
      step;
      mem_req_ready = 1'b0;
      #1;
      check("rstw_in_wait", stall, 1);
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h1234_5678;
      step;
      rst = 1'b0;
      dmem_sel = 2'b00;
      reg_we = 1'b0;
      #1;
      check("rstw_req_valid", mem_req_valid, 0);
      check("rstw_we", mem_we, 0);
      check("rstw_be", mem_be, 0);
      check("rstw_addr", mem_addr, 0);
      check("rstw_wdata", mem_wdata, 0);
      check("rstw_stall", stall, 0);
      check("rstw_misalign", misalign, 0);
      check("rstw_rf_we", rf_we, 0);
      step;
      mem_rsp_valid = 1'b0;
      last_rdata = 32'd0;
      run_op(2'b00, 3'b010, 32'h0, 32'd0, 32'h0, 32'd0, 5'd6, 1'b1, 2'b01, 0, 0, 32'd0);

      // randomized mix
      for (int n = 0; n < 120; n++) begin
         ds = 2'($urandom_range(0, 3));
         a = $urandom;
         if (ds == 2'b01) begin
            f3 = ld_f3[$urandom_range(0, 4)];
            ws = 2'b01;
         end else if (ds == 2'b10) begin
            f3 = 3'($urandom_range(0, 2));
            ws = 2'($urandom_range(0, 3));
         end else begin
            f3 = ld_f3[$urandom_range(0, 4)];
            ws = 2'($urandom_range(0, 3));
            if (ws == 2'b01) a[1:0] = 2'b00;
            if (ws == 2'b01 && f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
         end
         run_op(ds, f3, a, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), ws, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
